// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one fetch descriptor until its instruction arrives
// and ID takes it, dropping SRAM responses that belong to flushed requests.
module if_stage #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int EXC_W  = 8,
   parameter logic [PC_W-1:0] RESET_ORDER_PC = 32'h1BFF_FFFC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              excep_flush_i,
   input  logic              branch_flush_i,
   input  logic              pi_valid_i,
   input  logic              pi_req_i,
   input  logic [PC_W-1:0]   pi_pc_i,
   input  logic              pi_excep_en_i,
   input  logic [EXC_W-1:0]  pi_excep_type_i,
   output logic              if_allowin_o,
   input  logic              inst_ram_data_ok_i,
   input  logic [INST_W-1:0] inst_ram_rdata_i,
   input  logic              id_allowin_i,
   output logic              if_to_id_valid_o,
   output logic [PC_W-1:0]   if_to_id_pc_o,
   output logic [INST_W-1:0] if_to_id_inst_o,
   output logic              if_to_id_excep_en_o,
   output logic [EXC_W-1:0]  if_to_id_excep_type_o,
   output logic              order_we_o,
   output logic [PC_W-1:0]   order_pc_o
);

   logic              slot_valid_q, slot_valid_d;
   logic [PC_W-1:0]   slot_pc_q, slot_pc_d;
   logic              slot_req_q, slot_req_d;
   logic              slot_exc_en_q, slot_exc_en_d;
   logic [EXC_W-1:0]  slot_exc_type_q, slot_exc_type_d;
   logic              ibuf_valid_q, ibuf_valid_d;
   logic [INST_W-1:0] ibuf_inst_q, ibuf_inst_d;
   logic [1:0]        discard_cnt_q, discard_cnt_d;
   logic [PC_W-1:0]   order_pc_q, order_pc_d;

   logic flush;
   logic slot_wait;
   logic live_ok;
   logic ready_go;
   logic allowin;
   logic accept;
   logic xfer;

   // A response is ours only when nothing stale is still in flight ahead of it.
   assign flush     = excep_flush_i | branch_flush_i;
   assign slot_wait = slot_valid_q & slot_req_q & ~ibuf_valid_q;
   assign live_ok   = inst_ram_data_ok_i & (discard_cnt_q == 2'd0) & slot_wait;
   assign ready_go  = slot_valid_q & (slot_exc_en_q | ibuf_valid_q | live_ok);
   assign allowin   = ~slot_valid_q | (ready_go & id_allowin_i) | branch_flush_i;
   assign accept    = pi_valid_i & allowin & ~excep_flush_i;
   assign xfer      = ready_go & id_allowin_i;

   always_comb begin
      slot_valid_d    = slot_valid_q;
      slot_pc_d       = slot_pc_q;
      slot_req_d      = slot_req_q;
      slot_exc_en_d   = slot_exc_en_q;
      slot_exc_type_d = slot_exc_type_q;
      ibuf_valid_d    = ibuf_valid_q;
      ibuf_inst_d     = ibuf_inst_q;
      discard_cnt_d   = discard_cnt_q;
      order_pc_d      = order_pc_q;

      // A stale drop and a new stale request in the same cycle cancel out.
      if (inst_ram_data_ok_i && (discard_cnt_q != 2'd0))
         discard_cnt_d = discard_cnt_d - 2'd1;
      if (flush && slot_wait && !live_ok)
         discard_cnt_d = discard_cnt_d + 2'd1;

      if (flush || xfer) begin
         slot_valid_d = 1'b0;
         ibuf_valid_d = 1'b0;
      end else if (live_ok) begin
         ibuf_valid_d = 1'b1;
         ibuf_inst_d  = inst_ram_rdata_i;
      end

      if (accept) begin
         slot_valid_d    = 1'b1;
         slot_pc_d       = pi_pc_i;
         slot_req_d      = pi_req_i;
         slot_exc_en_d   = pi_excep_en_i;
         slot_exc_type_d = pi_excep_type_i;
         ibuf_valid_d    = 1'b0;
         order_pc_d      = pi_pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid_q    <= 1'b0;
         slot_pc_q       <= '0;
         slot_req_q      <= 1'b0;
         slot_exc_en_q   <= 1'b0;
         slot_exc_type_q <= '0;
         ibuf_valid_q    <= 1'b0;
         ibuf_inst_q     <= '0;
         discard_cnt_q   <= 2'd0;
         order_pc_q      <= RESET_ORDER_PC;
      end else begin
         slot_valid_q    <= slot_valid_d;
         slot_pc_q       <= slot_pc_d;
         slot_req_q      <= slot_req_d;
         slot_exc_en_q   <= slot_exc_en_d;
         slot_exc_type_q <= slot_exc_type_d;
         ibuf_valid_q    <= ibuf_valid_d;
         ibuf_inst_q     <= ibuf_inst_d;
         discard_cnt_q   <= discard_cnt_d;
         order_pc_q      <= order_pc_d;
      end
   end

   // At most one live request plus one post-flush request can be stale.
   assert property (@(posedge clk) disable iff (!rst_n) discard_cnt_q <= 2'd2);

   assign if_allowin_o          = allowin;
   assign if_to_id_valid_o      = ready_go & ~flush;
   assign if_to_id_pc_o         = slot_pc_q;
   assign if_to_id_inst_o       = (!slot_valid_q || slot_exc_en_q) ? '0 :
                                  ibuf_valid_q ? ibuf_inst_q : inst_ram_rdata_i;
   assign if_to_id_excep_en_o   = slot_valid_q & slot_exc_en_q;
   assign if_to_id_excep_type_o = slot_exc_type_q;
   assign order_we_o            = rst_n;
   assign order_pc_o            = order_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed cycle table for the documented scenarios, then
// random traffic checked against a request-queue model of pre-IF, SRAM and ID.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        excep_flush, branch_flush, pi_valid, pi_req, pi_exc;
   logic [31:0] pi_pc;
   logic [7:0]  pi_type;
   logic        allowin, dok, id_allowin;
   logic [31:0] rdata;
   logic        to_valid, to_exc, order_we;
   logic [31:0] to_pc, to_inst, order_pc;
   logic [7:0]  to_type;

   if_stage dut (
      .clk(clk), .rst_n(rst_n),
      .excep_flush_i(excep_flush), .branch_flush_i(branch_flush),
      .pi_valid_i(pi_valid), .pi_req_i(pi_req), .pi_pc_i(pi_pc),
      .pi_excep_en_i(pi_exc), .pi_excep_type_i(pi_type),
      .if_allowin_o(allowin),
      .inst_ram_data_ok_i(dok), .inst_ram_rdata_i(rdata),
      .id_allowin_i(id_allowin),
      .if_to_id_valid_o(to_valid), .if_to_id_pc_o(to_pc), .if_to_id_inst_o(to_inst),
      .if_to_id_excep_en_o(to_exc), .if_to_id_excep_type_o(to_type),
      .order_we_o(order_we), .order_pc_o(order_pc)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ctl = {excep_flush, branch_flush, pi_valid, pi_req, pi_exc, data_ok, id_allowin}
   // eflg = {valid, allowin, check_payload, excep_en}
   typedef struct {
      logic [6:0]  ctl;
      logic [31:0] ppc;
      logic [7:0]  ptype;
      logic [31:0] rdata;
      logic [3:0]  eflg;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [7:0]  etype;
      logic [31:0] eopc;
   } vec_t;

   vec_t tbl[29];

   task automatic idle_inputs();
      {excep_flush, branch_flush, pi_valid, pi_req, pi_exc, dok} = 6'b0;
      id_allowin = 1'b1;
      pi_pc = 32'h0; pi_type = 8'h0; rdata = 32'h0;
   endtask

   task automatic apply_row(input int idx);
      vec_t r;
      r = tbl[idx];
      {excep_flush, branch_flush, pi_valid, pi_req, pi_exc, dok, id_allowin} = r.ctl;
      pi_pc = r.ppc; pi_type = r.ptype; rdata = r.rdata;
      @(negedge clk);
      chk($sformatf("row%0d valid", idx), 32'(to_valid), 32'(r.eflg[3]));
      chk($sformatf("row%0d allowin", idx), 32'(allowin), 32'(r.eflg[2]));
      chk($sformatf("row%0d order_pc", idx), order_pc, r.eopc);
      if (r.eflg[1]) begin
         chk($sformatf("row%0d pc", idx), to_pc, r.epc);
         chk($sformatf("row%0d inst", idx), to_inst, r.einst);
         chk($sformatf("row%0d exc_en", idx), 32'(to_exc), 32'(r.eflg[0]));
         chk($sformatf("row%0d exc_type", idx), 32'(to_type), 32'(r.etype));
      end
      $display("row %0d: ctl=%b pc_in=%h valid=%b pc=%h inst=%h order_pc=%h",
               idx, r.ctl, r.ppc, to_valid, to_pc, to_inst, order_pc);
      @(posedge clk);
      #1;
   endtask

   // Reference model: in-order queue of issued SRAM requests, each either still
   // owned by the held descriptor or orphaned by a flush.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          stale;
   } req_t;
   req_t q[$];
   req_t f;
   bit          h_valid, h_exc, h_has;
   logic [31:0] h_pc, h_inst, m_order;
   logic [7:0]  h_type;
   bit          front_live, ready, e_valid, e_allow, xfer;
   logic [31:0] e_inst;

   initial begin
      tbl[0]  = '{7'b0011001, 32'h1C000000, 8'h00, 32'h00000000, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1BFFFFFC};
      tbl[1]  = '{7'b0000011, 32'h0, 8'h00, 32'h02800C21, 4'b1110, 32'h1C000000, 32'h02800C21, 8'h00, 32'h1C000000};
      tbl[2]  = '{7'b0011001, 32'h1C000004, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000000};
      tbl[3]  = '{7'b0011010, 32'h1C000008, 8'h00, 32'h12345678, 4'b1010, 32'h1C000004, 32'h12345678, 8'h00, 32'h1C000004};
      tbl[4]  = '{7'b0011000, 32'h1C000008, 8'h00, 32'hDEADBEEF, 4'b1010, 32'h1C000004, 32'h12345678, 8'h00, 32'h1C000004};
      tbl[5]  = '{7'b0011000, 32'h1C000008, 8'h00, 32'hDEADBEEF, 4'b1010, 32'h1C000004, 32'h12345678, 8'h00, 32'h1C000004};
      tbl[6]  = '{7'b0011001, 32'h1C000008, 8'h00, 32'hDEADBEEF, 4'b1110, 32'h1C000004, 32'h12345678, 8'h00, 32'h1C000004};
      tbl[7]  = '{7'b1011001, 32'h1C008000, 8'h00, 32'h0, 4'b0000, 32'h0, 32'h0, 8'h00, 32'h1C000008};
      tbl[8]  = '{7'b0011001, 32'h1C008000, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000008};
      tbl[9]  = '{7'b0000011, 32'h0, 8'h00, 32'hBAD0BAD0, 4'b0000, 32'h0, 32'h0, 8'h00, 32'h1C008000};
      tbl[10] = '{7'b0000011, 32'h0, 8'h00, 32'h03400000, 4'b1110, 32'h1C008000, 32'h03400000, 8'h00, 32'h1C008000};
      tbl[11] = '{7'b0011001, 32'h1C000010, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C008000};
      tbl[12] = '{7'b0111001, 32'h1C000100, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000010};
      tbl[13] = '{7'b0000011, 32'h0, 8'h00, 32'hBAD1BAD1, 4'b0000, 32'h0, 32'h0, 8'h00, 32'h1C000100};
      tbl[14] = '{7'b0000011, 32'h0, 8'h00, 32'h00112233, 4'b1110, 32'h1C000100, 32'h00112233, 8'h00, 32'h1C000100};
      tbl[15] = '{7'b0011001, 32'h1C000200, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000100};
      tbl[16] = '{7'b0100011, 32'h0, 8'h00, 32'h11111111, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000200};
      tbl[17] = '{7'b0011001, 32'h1C000300, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000200};
      tbl[18] = '{7'b0000011, 32'h0, 8'h00, 32'h22222222, 4'b1110, 32'h1C000300, 32'h22222222, 8'h00, 32'h1C000300};
      tbl[19] = '{7'b0010101, 32'h1C000400, 8'h08, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000300};
      tbl[20] = '{7'b0000001, 32'h0, 8'h00, 32'hFFFFFFFF, 4'b1111, 32'h1C000400, 32'h0, 8'h08, 32'h1C000400};
      tbl[21] = '{7'b0011001, 32'h1C000500, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000400};
      tbl[22] = '{7'b0011011, 32'h1C000504, 8'h00, 32'h000000A1, 4'b1110, 32'h1C000500, 32'h000000A1, 8'h00, 32'h1C000500};
      tbl[23] = '{7'b0000011, 32'h0, 8'h00, 32'h000000A2, 4'b1110, 32'h1C000504, 32'h000000A2, 8'h00, 32'h1C000504};
      tbl[24] = '{7'b0000001, 32'h0, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000504};
      tbl[25] = '{7'b0011001, 32'h1C000600, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000504};
      tbl[26] = '{7'b0111001, 32'h1C000700, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1C000600};
      tbl[27] = '{7'b0011001, 32'h1C000800, 8'h00, 32'h0, 4'b0100, 32'h0, 32'h0, 8'h00, 32'h1BFFFFFC};
      tbl[28] = '{7'b0000011, 32'h0, 8'h00, 32'h0C0FFEE0, 4'b1110, 32'h1C000800, 32'h0C0FFEE0, 8'h00, 32'h1C000800};

      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_reset order_we", 32'(order_we), 32'd0);
      chk("in_reset valid", 32'(to_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("reset order_we", 32'(order_we), 32'd1);
      chk("reset allowin", 32'(allowin), 32'd1);
      chk("reset order_pc", order_pc, 32'h1BFFFFFC);
      chk("reset pc", to_pc, 32'h0);
      chk("reset inst", to_inst, 32'h0);
      chk("reset exc_en", 32'(to_exc), 32'd0);
      chk("reset exc_type", 32'(to_type), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i <= 26; i++) apply_row(i);

      // Asynchronous reset with a request outstanding and one stale response pending.
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst valid", 32'(to_valid), 32'd0);
      chk("midrst allowin", 32'(allowin), 32'd1);
      chk("midrst order_pc", order_pc, 32'h1BFFFFFC);
      chk("midrst order_we", 32'(order_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 27; i <= 28; i++) apply_row(i);

      // Random traffic against the queue model, from a fresh reset.
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      h_valid = 0; h_exc = 0; h_has = 0; h_pc = 0; h_inst = 0; h_type = 0;
      m_order = 32'h1BFFFFFC;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         excep_flush  = ($urandom_range(0, 15) == 0);
         branch_flush = ($urandom_range(0, 11) == 0);
         id_allowin   = ($urandom_range(0, 3) != 0);
         dok          = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         rdata        = dok ? q[0].inst : $urandom;
         pi_valid     = (q.size() < 2) && ($urandom_range(0, 2) != 0);
         pi_exc       = pi_valid && ($urandom_range(0, 7) == 0);
         pi_req       = pi_valid && !pi_exc;
         pi_pc        = $urandom & 32'hFFFF_FFFC;
         pi_type      = pi_exc ? 8'($urandom) : 8'h00;

         front_live = dok && !q[0].stale;
         if (front_live && !(h_valid && !h_exc && !h_has))
            chk("model response ownership", 32'd0, 32'd1);
         ready   = h_valid && (h_exc || h_has || front_live);
         e_valid = ready && !branch_flush && !excep_flush;
         e_allow = !h_valid || (ready && id_allowin) || branch_flush;
         e_inst  = h_exc ? 32'h0 : (h_has ? h_inst : rdata);

         @(negedge clk);
         chk("rnd valid", 32'(to_valid), 32'(e_valid));
         chk("rnd allowin", 32'(allowin), 32'(e_allow));
         chk("rnd order_pc", order_pc, m_order);
         if (e_valid) begin
            chk("rnd pc", to_pc, h_pc);
            chk("rnd inst", to_inst, e_inst);
            chk("rnd exc_en", 32'(to_exc), 32'(h_exc));
            chk("rnd exc_type", 32'(to_type), 32'(h_type));
            if (id_allowin)
               $display("cyc %0d: to ID pc=%h inst=%h exc=%b", cyc, h_pc, e_inst, h_exc);
         end

         @(posedge clk);
         xfer = ready && id_allowin;
         if (dok) begin
            f = q.pop_front();
            if (!f.stale && !xfer && !branch_flush && !excep_flush) begin
               h_has  = 1;
               h_inst = f.inst;
            end
         end
         if (branch_flush || excep_flush)
            foreach (q[i]) q[i].stale = 1;
         if (branch_flush || excep_flush || xfer) begin
            h_valid = 0;
            h_has   = 0;
         end
         if (pi_valid && e_allow && !excep_flush) begin
            h_valid = 1; h_pc = pi_pc; h_exc = pi_exc; h_type = pi_type; h_has = 0;
            m_order = pi_pc;
            if (pi_req) q.push_back('{pi_pc, $urandom, 1'b0});
         end
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
